mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter DM_WORDS, default 4096, data-memory size in 32-bit words; byte addresses at or above DM_WORDS*4 are out of range.
REQ-002 SHALL have parameter PC_RESET, default 32'h0000_3000, value of m_inst_addr and w_inst_addr after reset.
REQ-003 clk  in  1  single clock; all registers update on posedge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 hold  in  1  freeze the E/M register (M keeps its instruction).
REQ-006 flush  in  1  load a bubble into the E/M register.
REQ-007 e_pc  in  32  PC of the instruction leaving E.
REQ-008 e_mem_op  in  4  memory op code: NONE, LW, LH, LHU, LB, LBU, SW, SH, SB.
REQ-009 e_alu_res  in  32  ALU result; this is the effective address for memory ops.
REQ-010 e_rt_data / e_rt_addr  in  32 / 5  store data and its source register.
REQ-011 e_rd_we / e_rd_addr  in  1 / 5  writeback enable and destination.
REQ-012 m_data_addr, m_data_wdata  out  32 each  memory address and lane-replicated write data.
REQ-013 m_data_byteen  out  4  byte write enables; 0 means no write.
REQ-014 m_data_rdata  in  32  asynchronous word read of m_data_addr.
REQ-015 m_inst_addr  out  32  PC of the instruction in M.
REQ-016 m_fwd_valid / m_fwd_addr / m_fwd_data  out  1 / 5 / 32  M-stage forward of ALU results; m_fwd_valid is 0 for loads.
REQ-017 w_grf_we / w_grf_addr / w_grf_wdata / w_inst_addr  out  1 / 5 / 32 / 32  registered writeback to the GRF.
REQ-018 align_err  out  1  sticky flag, set by any misaligned or out-of-range memory op.

Function
REQ-019 E/M register SHALL capture e_* at each posedge. Priority: flush (loads a bubble: op NONE, we 0, pc unchanged) over hold (retains contents) over normal load.
REQ-020 M/W register SHALL capture every posedge and is never held. Total latency is one cycle from the E/M edge to the memory ports, then one more edge to w_*.
REQ-021 m_data_addr SHALL equal the M-stage ALU result for every op, including NONE.
REQ-022 Store data SHALL be forwarded from writeback when w_grf_we=1, w_grf_addr=m_rt_addr and m_rt_addr is not 0; otherwise the registered rt data is used.
REQ-023 Write data and byte enables per op:
- SW: byteen 1111, data as is.
- SH: data {h,h}; byteen 1100 when addr[1]=1, else 0011.
- SB: data {b,b,b,b}; byteen 0001 shifted left by addr[1:0].
- Any other op: byteen 0000.
REQ-024 Misalignment is a word op with addr[1:0] not 00, or a half op with addr[0]=1. A misaligned or out-of-range op SHALL force byteen 0000 and w_grf_we 0, and SHALL set align_err.
REQ-025 Load extraction: LW returns the whole word. LH/LHU select the half by addr[1]; LB/LBU select the byte by addr[1:0]. H and B sign-extend; HU and BU zero-extend.
REQ-026 w_grf_wdata SHALL be the extracted load data for load ops and the ALU result otherwise.
REQ-027 w_grf_we SHALL be 0 whenever the captured rd_addr is 0.
REQ-028 A store in M and a load in W to the same word in the same cycle need no special handling; memory timing resolves it.

Reset
REQ-029 While reset is high, E/M SHALL hold a bubble and M/W SHALL hold we 0.
REQ-030 During reset: addresses and data outputs 0, byteen 0000, m_fwd_valid 0, align_err 0, m_inst_addr and w_inst_addr equal PC_RESET.
REQ-031 Reset asserted mid-store SHALL drop byteen to 0 immediately (asynchronously), with no partial write.

Structure
REQ-032 Shared package mem_pkg SHALL hold the mem_op enumeration, the byteen constants and DM_WORDS.
REQ-033 Byte/half selection and extension SHALL live in one sub-module, load_ext, driven by op, addr[1:0] and rdata.

Verification
REQ-034 SB to addr 0x0000_0006 with rt=0x1234_56AB -> byteen 0100, wdata 0xABABABAB.
REQ-035 mem[0x10]=0x8000_F0FF. LB at 0x11 -> 0xFFFF_FFF0. LBU at 0x11 -> 0x0000_00F0. LH at 0x12 -> 0xFFFF_8000. Each appears on w_grf_wdata exactly one cycle after its M cycle.
REQ-036 LW $5 followed by SW $5 to 0x20 (load returns 0xDEAD_BEEF) -> store wdata 0xDEADBEEF via W forwarding.
REQ-037 LW at 0x0000_0002 -> byteen 0000, w_grf_we 0, align_err=1 and it stays 1 until reset.
REQ-038 hold=1 for 2 cycles with SW in M -> byteen 1111 for 3 cycles. flush=1 and hold=1 together -> bubble, byteen 0000 on the next cycle.
REQ-039 Reset pulse while an SH is in M -> byteen 0000 within the same cycle, with no memory write logged.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared memory-op encoding, byte-enable constants and stage register layout
package mem_pkg;

    localparam int DM_WORDS = 4096;

    typedef enum logic [3:0] {
        OP_NONE = 4'd0,
        OP_LW   = 4'd1,
        OP_LH   = 4'd2,
        OP_LHU  = 4'd3,
        OP_LB   = 4'd4,
        OP_LBU  = 4'd5,
        OP_SW   = 4'd6,
        OP_SH   = 4'd7,
        OP_SB   = 4'd8
    } mem_op_t;

    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_WORD = 4'b1111;
    localparam logic [3:0] BE_HI   = 4'b1100;
    localparam logic [3:0] BE_LO   = 4'b0011;
    localparam logic [3:0] BE_BYTE = 4'b0001;

    typedef struct packed {
        logic [31:0] pc;
        mem_op_t     op;
        logic [31:0] alu;
        logic [31:0] rt_data;
        logic [4:0]  rt_addr;
        logic        rd_we;
        logic [4:0]  rd_addr;
    } em_t;

    function automatic logic is_load(mem_op_t op);
        return op inside {OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU};
    endfunction

    function automatic logic is_store(mem_op_t op);
        return op inside {OP_SW, OP_SH, OP_SB};
    endfunction

    function automatic logic is_word(mem_op_t op);
        return op inside {OP_LW, OP_SW};
    endfunction

    function automatic logic is_half(mem_op_t op);
        return op inside {OP_LH, OP_LHU, OP_SH};
    endfunction

endpackage

// File: rtl/load_ext.sv
// load_ext: selects the addressed half/byte of a read word and sign/zero-extends it
module load_ext
    import mem_pkg::*;
(
    input  mem_op_t     op,
    input  logic [1:0]  addr,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [15:0] half;
    logic [7:0]  byte_v;

    assign half   = addr[1] ? rdata[31:16] : rdata[15:0];
    assign byte_v = 8'(rdata >> {addr, 3'b000});

    always_comb begin
        data = op == OP_LH  ? {{16{half[15]}}, half} :
               op == OP_LHU ? {16'h0, half} :
               op == OP_LB  ? {{24{byte_v[7]}}, byte_v} :
               op == OP_LBU ? {24'h0, byte_v} :
               rdata;
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: E/M and M/W pipeline registers with store lane steering, load extraction and alignment checks
module mem_stage
    import mem_pkg::*;
#(
    parameter int          DM_WORDS = mem_pkg::DM_WORDS,
    parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hold,
    input  logic        flush,
    input  logic [31:0] e_pc,
    input  logic [3:0]  e_mem_op,
    input  logic [31:0] e_alu_res,
    input  logic [31:0] e_rt_data,
    input  logic [4:0]  e_rt_addr,
    input  logic        e_rd_we,
    input  logic [4:0]  e_rd_addr,
    output logic [31:0] m_data_addr,
    output logic [31:0] m_data_wdata,
    output logic [3:0]  m_data_byteen,
    input  logic [31:0] m_data_rdata,
    output logic [31:0] m_inst_addr,
    output logic        m_fwd_valid,
    output logic [4:0]  m_fwd_addr,
    output logic [31:0] m_fwd_data,
    output logic        w_grf_we,
    output logic [4:0]  w_grf_addr,
    output logic [31:0] w_grf_wdata,
    output logic [31:0] w_inst_addr,
    output logic        align_err
);

    localparam logic [32:0] ADDR_LIM = 33'(DM_WORDS) << 2;

    em_t         em;
    logic [31:0] st_data;
    logic [31:0] ld_data;
    logic [3:0]  be_raw;
    logic        m_load;
    logic        m_err;
    logic        align_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            em.pc      <= PC_RESET;
            em.op      <= OP_NONE;
            em.alu     <= '0;
            em.rt_data <= '0;
            em.rt_addr <= '0;
            em.rd_we   <= 1'b0;
            em.rd_addr <= '0;
        end else if (flush) begin
            em.op    <= OP_NONE;
            em.rd_we <= 1'b0;
        end else if (!hold) begin
            em.pc      <= e_pc;
            em.op      <= mem_op_t'(e_mem_op);
            em.alu     <= e_alu_res;
            em.rt_data <= e_rt_data;
            em.rt_addr <= e_rt_addr;
            em.rd_we   <= e_rd_we;
            em.rd_addr <= e_rd_addr;
        end
    end

    assign m_load = is_load(em.op);
    assign m_err  = (m_load || is_store(em.op)) &&
                    ((is_word(em.op) && em.alu[1:0] != 2'b00) ||
                     (is_half(em.op) && em.alu[0]) ||
                     {1'b0, em.alu} >= ADDR_LIM);

    // A load sitting in W has not reached the GRF yet, so a dependent store takes it from there
    assign st_data = (w_grf_we && w_grf_addr == em.rt_addr && em.rt_addr != 5'd0) ? w_grf_wdata : em.rt_data;

    assign be_raw = em.op == OP_SW ? BE_WORD :
                    em.op == OP_SH ? (em.alu[1] ? BE_HI : BE_LO) :
                    em.op == OP_SB ? BE_BYTE << em.alu[1:0] :
                    BE_NONE;

    assign m_data_addr   = em.alu;
    assign m_data_byteen = m_err ? BE_NONE : be_raw;
    assign m_data_wdata  = em.op == OP_SH ? {2{st_data[15:0]}} :
                           em.op == OP_SB ? {4{st_data[7:0]}} :
                           st_data;
    assign m_inst_addr   = em.pc;
    assign m_fwd_valid   = em.rd_we && em.rd_addr != 5'd0 && !m_load;
    assign m_fwd_addr    = em.rd_addr;
    assign m_fwd_data    = em.alu;

    load_ext u_load_ext (
        .op    (em.op),
        .addr  (em.alu[1:0]),
        .rdata (m_data_rdata),
        .data  (ld_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_grf_we    <= 1'b0;
            w_grf_addr  <= '0;
            w_grf_wdata <= '0;
            w_inst_addr <= PC_RESET;
            align_q     <= 1'b0;
        end else begin
            w_grf_we    <= em.rd_we && em.rd_addr != 5'd0 && !m_err;
            w_grf_addr  <= em.rd_addr;
            w_grf_wdata <= m_load ? ld_data : em.alu;
            w_inst_addr <= em.pc;
            align_q     <= align_q | m_err;
        end
    end

    // The faulting op flags in its own M cycle; the register keeps it set afterwards
    assign align_err = align_q | m_err;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed-vector bench for mem_stage with a byte-enabled data memory model
module tb_mem_stage;
    import mem_pkg::*;

    localparam logic [31:0] PC_RST = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        hold = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] e_pc = '0;
    logic [3:0]  e_mem_op = '0;
    logic [31:0] e_alu_res = '0;
    logic [31:0] e_rt_data = '0;
    logic [4:0]  e_rt_addr = '0;
    logic        e_rd_we = 1'b0;
    logic [4:0]  e_rd_addr = '0;
    logic [31:0] m_data_addr, m_data_wdata, m_data_rdata;
    logic [3:0]  m_data_byteen;
    logic [31:0] m_inst_addr, m_fwd_data, w_grf_wdata, w_inst_addr;
    logic        m_fwd_valid, w_grf_we, align_err;
    logic [4:0]  m_fwd_addr, w_grf_addr;

    logic [31:0] mem [0:4095];
    int          wr_count = 0;
    int          total = 0;
    int          fails = 0;
    int          saved;

    mem_stage #(.DM_WORDS(4096), .PC_RESET(PC_RST)) dut (
        .clk(clk), .reset(reset), .hold(hold), .flush(flush),
        .e_pc(e_pc), .e_mem_op(e_mem_op), .e_alu_res(e_alu_res),
        .e_rt_data(e_rt_data), .e_rt_addr(e_rt_addr),
        .e_rd_we(e_rd_we), .e_rd_addr(e_rd_addr),
        .m_data_addr(m_data_addr), .m_data_wdata(m_data_wdata),
        .m_data_byteen(m_data_byteen), .m_data_rdata(m_data_rdata),
        .m_inst_addr(m_inst_addr), .m_fwd_valid(m_fwd_valid),
        .m_fwd_addr(m_fwd_addr), .m_fwd_data(m_fwd_data),
        .w_grf_we(w_grf_we), .w_grf_addr(w_grf_addr),
        .w_grf_wdata(w_grf_wdata), .w_inst_addr(w_inst_addr),
        .align_err(align_err)
    );

    always #5 clk = ~clk;

    assign m_data_rdata = mem[m_data_addr[13:2]];

    always @(posedge clk) begin
        if (reset) begin
            mem[4]  <= 32'h8000_F0FF;
            mem[16] <= 32'hDEAD_BEEF;
        end else if (m_data_byteen != 4'b0000) begin
            for (int b = 0; b < 4; b++)
                if (m_data_byteen[b]) mem[m_data_addr[13:2]][8*b +: 8] <= m_data_wdata[8*b +: 8];
            wr_count <= wr_count + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] alu, input logic [31:0] rt,
                         input logic [4:0] rta, input logic we, input logic [4:0] rd, input logic [31:0] pc);
        e_mem_op  = op;
        e_alu_res = alu;
        e_rt_data = rt;
        e_rt_addr = rta;
        e_rd_we   = we;
        e_rd_addr = rd;
        e_pc      = pc;
    endtask

    initial begin
        tick();
        tick();
        chk("rst_byteen", 32'(m_data_byteen), 32'h0);
        chk("rst_daddr", m_data_addr, 32'h0);
        chk("rst_wdata", m_data_wdata, 32'h0);
        chk("rst_fwd_valid", 32'(m_fwd_valid), 32'h0);
        chk("rst_align", 32'(align_err), 32'h0);
        chk("rst_m_pc", m_inst_addr, PC_RST);
        chk("rst_w_pc", w_inst_addr, PC_RST);
        chk("rst_w_we", 32'(w_grf_we), 32'h0);
        reset = 1'b0;

        drive(OP_SB, 32'h6, 32'h1234_56AB, 5'd3, 1'b0, 5'd0, 32'h3004);
        tick();
        chk("sb_byteen", 32'(m_data_byteen), 32'h4);
        chk("sb_wdata", m_data_wdata, 32'hABAB_ABAB);
        chk("sb_daddr", m_data_addr, 32'h6);
        chk("sb_m_pc", m_inst_addr, 32'h3004);

        drive(OP_LB, 32'h11, 32'h0, 5'd0, 1'b1, 5'd2, 32'h3008);
        tick();
        chk("sb_w_we", 32'(w_grf_we), 32'h0);
        chk("sb_w_pc", w_inst_addr, 32'h3004);
        chk("lb_fwd_valid", 32'(m_fwd_valid), 32'h0);
        chk("sb_mem", 32'(mem[1][23:16]), 32'hAB);

        drive(OP_LBU, 32'h11, 32'h0, 5'd0, 1'b1, 5'd3, 32'h300C);
        tick();
        chk("lb_data", w_grf_wdata, 32'hFFFF_FFF0);
        chk("lb_we", 32'(w_grf_we), 32'h1);
        chk("lb_addr", 32'(w_grf_addr), 32'h2);

        drive(OP_LH, 32'h12, 32'h0, 5'd0, 1'b1, 5'd4, 32'h3010);
        tick();
        chk("lbu_data", w_grf_wdata, 32'h0000_00F0);

        drive(OP_NONE, 32'h55, 32'h0, 5'd0, 1'b1, 5'd7, 32'h3014);
        tick();
        chk("lh_data", w_grf_wdata, 32'hFFFF_8000);
        chk("alu_fwd_valid", 32'(m_fwd_valid), 32'h1);
        chk("alu_fwd_data", m_fwd_data, 32'h55);
        chk("alu_fwd_addr", 32'(m_fwd_addr), 32'h7);
        chk("alu_daddr", m_data_addr, 32'h55);
        chk("alu_byteen", 32'(m_data_byteen), 32'h0);

        drive(OP_LW, 32'h40, 32'h0, 5'd0, 1'b1, 5'd5, 32'h3018);
        tick();
        chk("lw_fwd_valid", 32'(m_fwd_valid), 32'h0);
        chk("alu_w_data", w_grf_wdata, 32'h55);

        drive(OP_SW, 32'h20, 32'h0, 5'd5, 1'b0, 5'd0, 32'h301C);
        tick();
        chk("fwd_sw_wdata", m_data_wdata, 32'hDEAD_BEEF);
        chk("fwd_sw_byteen", 32'(m_data_byteen), 32'hF);
        chk("fwd_w_addr", 32'(w_grf_addr), 32'h5);

        drive(OP_SH, 32'h22, 32'h1111_CAFE, 5'd8, 1'b0, 5'd0, 32'h3020);
        tick();
        chk("sh_byteen", 32'(m_data_byteen), 32'hC);
        chk("sh_wdata", m_data_wdata, 32'hCAFE_CAFE);
        chk("sw_mem", mem[8], 32'hDEAD_BEEF);

        drive(OP_SW, 32'h30, 32'h0102_0304, 5'd9, 1'b0, 5'd0, 32'h3100);
        tick();
        chk("hold_c0", 32'(m_data_byteen), 32'hF);
        hold = 1'b1;
        drive(OP_NONE, 32'h0, 32'h0, 5'd0, 1'b0, 5'd0, 32'h3104);
        tick();
        chk("hold_c1", 32'(m_data_byteen), 32'hF);
        tick();
        chk("hold_c2", 32'(m_data_byteen), 32'hF);
        chk("hold_pc", m_inst_addr, 32'h3100);
        hold = 1'b0;
        tick();
        chk("hold_release", 32'(m_data_byteen), 32'h0);

        drive(OP_SW, 32'h34, 32'h0, 5'd0, 1'b0, 5'd0, 32'h3108);
        tick();
        chk("pre_flush", 32'(m_data_byteen), 32'hF);
        flush = 1'b1;
        hold = 1'b1;
        drive(OP_SW, 32'h38, 32'h0, 5'd0, 1'b1, 5'd9, 32'h310C);
        tick();
        chk("flush_byteen", 32'(m_data_byteen), 32'h0);
        chk("flush_pc", m_inst_addr, 32'h3108);
        chk("flush_fwd", 32'(m_fwd_valid), 32'h0);
        flush = 1'b0;
        hold = 1'b0;

        drive(OP_NONE, 32'h0, 32'h0, 5'd0, 1'b0, 5'd0, 32'h3110);
        tick();
        chk("pre_mis_align", 32'(align_err), 32'h0);
        drive(OP_LW, 32'h2, 32'h0, 5'd0, 1'b1, 5'd6, 32'h3200);
        tick();
        chk("mis_lw_byteen", 32'(m_data_byteen), 32'h0);
        chk("mis_lw_align", 32'(align_err), 32'h1);
        drive(OP_SH, 32'h21, 32'h0, 5'd0, 1'b0, 5'd0, 32'h3204);
        tick();
        chk("mis_lw_w_we", 32'(w_grf_we), 32'h0);
        chk("mis_lw_w_pc", w_inst_addr, 32'h3200);
        chk("mis_sh_byteen", 32'(m_data_byteen), 32'h0);
        drive(OP_SW, 32'h4000, 32'h0, 5'd0, 1'b0, 5'd0, 32'h3208);
        tick();
        chk("oor_sw_byteen", 32'(m_data_byteen), 32'h0);
        drive(OP_SW, 32'h3FFC, 32'h5A5A_5A5A, 5'd0, 1'b0, 5'd0, 32'h320C);
        tick();
        chk("edge_sw_byteen", 32'(m_data_byteen), 32'hF);
        drive(OP_NONE, 32'h0, 32'h0, 5'd0, 1'b0, 5'd0, 32'h3210);
        tick();
        tick();
        chk("align_sticky", 32'(align_err), 32'h1);
        reset = 1'b1;
        tick();
        chk("align_cleared", 32'(align_err), 32'h0);
        reset = 1'b0;

        drive(OP_SH, 32'h24, 32'h0000_ABCD, 5'd0, 1'b0, 5'd0, 32'h3300);
        tick();
        chk("rsh_byteen", 32'(m_data_byteen), 32'h3);
        saved = wr_count;
        #3;
        reset = 1'b1;
        #1;
        chk("rsh_async_byteen", 32'(m_data_byteen), 32'h0);
        chk("rsh_async_pc", m_inst_addr, PC_RST);
        tick();
        chk("rsh_no_write", 32'(wr_count), 32'(saved));
        reset = 1'b0;
        tick();

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
